// File: rtl/bidirectional_3bit_counter.sv
// 3-bit up/down counter with parallel load, built from three JK flip-flops.
// The jkff cell below is also delivered and tested on its own.

module jkff (
    output logic q,
    output logic qbar,
    input  logic j,
    input  logic k,
    input  logic clk,
    input  logic clr
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00: q <= q;
                2'b01: q <= 1'b0;
                2'b10: q <= 1'b1;
                2'b11: q <= ~q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

module bidirectional_3bit_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       mode,
    input  logic       set,
    input  logic [2:0] setnum,
    output logic [2:0] count
);

    logic [2:0] q;
    logic [2:0] qb;
    logic [2:0] t;
    logic [2:0] j;
    logic [2:0] k;
    logic       unused_qb2;

    // Up: toggle when all lower bits are 1; down: when all lower bits are 0.
    always_comb begin
        t    = 3'b000;
        t[0] = 1'b1;
        t[1] = mode ? qb[0] : q[0];
        t[2] = mode ? (qb[0] & qb[1]) : (q[0] & q[1]);
    end

    // A load drives each cell with j=d, k=~d so it lands on d regardless of state.
    always_comb begin
        j = t;
        k = t;
        if (set) begin
            j = setnum;
            k = ~setnum;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_cell
        jkff u_ff (
            .q    (q[i]),
            .qbar (qb[i]),
            .j    (j[i]),
            .k    (k[i]),
            .clk  (clk),
            .clr  (clr)
        );
    end

    assign unused_qb2 = qb[2];
    assign count      = q;

endmodule

// File: tb/tb_bidirectional_3bit_counter.sv
// Randomised bench for bidirectional_3bit_counter and its jkff cell,
// checked against an arithmetic modulo-8 reference model.

module tb_bidirectional_3bit_counter;

    logic       clk;
    logic       clr;
    logic       mode;
    logic       set;
    logic [2:0] setnum;
    logic [2:0] count;

    logic jq, jqb, jj, jk, jclk, jclr;

    int checks;
    int errors;
    int m_cnt;
    int m_q;

    bidirectional_3bit_counter dut (
        .clk    (clk),
        .clr    (clr),
        .mode   (mode),
        .set    (set),
        .setnum (setnum),
        .count  (count)
    );

    jkff u_cell (
        .q    (jq),
        .qbar (jqb),
        .j    (jj),
        .k    (jk),
        .clk  (jclk),
        .clr  (jclr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got,
                         input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // One counter cycle: drive at negedge, check after the next posedge.
    task automatic cyc(input string tag, input logic c, input logic m,
                       input logic s, input logic [2:0] sn);
        @(negedge clk);
        clr    = c;
        mode   = m;
        set    = s;
        setnum = sn;
        #1;
        if (c) begin
            m_cnt = 0;
            check("clr_async", count, 3'd0);
        end
        @(posedge clk);
        #1;
        if (!c) begin
            if (s) m_cnt = int'(sn);
            else if (m) m_cnt = (m_cnt + 7) % 8;
            else m_cnt = (m_cnt + 1) % 8;
        end
        check(tag, count, 3'(m_cnt));
    endtask

    task automatic cell_step(input logic c, input logic a, input logic b,
                             input logic e);
        jclk = 1'b0;
        #1;
        jclr = c;
        jj   = a;
        jk   = b;
        #1;
        if (e) jclk = 1'b1;
        #1;
        if (c) m_q = 0;
        else if (e) begin
            if (a && b) m_q = 1 - m_q;
            else if (a) m_q = 1;
            else if (b) m_q = 0;
        end
        check("jk_q", {2'b00, jq}, 3'(m_q));
        check("jk_qbar", {2'b00, jqb}, 3'(1 - m_q));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_cnt  = 0;
        m_q    = 0;
        clr    = 1'b1;
        mode   = 1'b0;
        set    = 1'b0;
        setnum = 3'd0;
        jclk   = 1'b0;
        jclr   = 1'b1;
        jj     = 1'b0;
        jk     = 1'b0;

        #1;
        check("reset_async", count, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", count, 3'd0);

        // jkff: clear, then sweep {clr,j,k,clk} twice to visit both q states.
        #1 jclr = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                cell_step(i[3], i[2], i[1], i[0]);
            end
            cell_step(1'b0, 1'b1, 1'b0, 1'b1);
        end

        // Up with wrap: 1..7,0,1.
        for (int i = 0; i < 9; i++) cyc("up", 1'b0, 1'b0, 1'b0, 3'd0);
        check("up_end", count, 3'd1);

        cyc("clear", 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) cyc("down", 1'b0, 1'b1, 1'b0, 3'd0);
        check("down_end", count, 3'd5);

        cyc("load3", 1'b0, 1'b0, 1'b1, 3'd3);
        cyc("load_prio", 1'b0, 1'b1, 1'b1, 3'd5);
        check("load_val", count, 3'd5);
        cyc("after_load", 1'b0, 1'b0, 1'b0, 3'd0);
        check("after_load_val", count, 3'd6);

        // Clear between edges, then resume counting.
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        m_cnt = 0;
        check("mid_clr", count, 3'd0);
        cyc("resume", 1'b0, 1'b0, 1'b0, 3'd0);
        check("resume_val", count, 3'd1);

        for (int i = 0; i < 300; i++) begin
            cyc("rand", ($urandom_range(15) == 0), 1'($urandom),
                ($urandom_range(3) == 0), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=0 want=1");
        $fatal(1);
    end

endmodule
